// File: rtl/cs_win.sv
// Sliding-window approximate-average engine: Y = (sum + WIN*X_appr) >> SHIFT over the last WIN accepted samples.
// Optional round-half-up output scaling is enabled by defining CS_ROUND_EN (default build floors).
module cs_win #(
    parameter int DATA_W = 8,
    parameter int WIN    = 9,
    parameter int SHIFT  = 3,
    parameter int OUT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] X,
    input  logic              in_valid,
    input  logic              clear,
    output logic [OUT_W-1:0]  Y,
    output logic              out_valid
);
    localparam int PW = $clog2(WIN);
    localparam int CW = $clog2(WIN + 1);
    localparam int SW = DATA_W + $clog2(WIN);
    // Extra SHIFT bits keep the rounding add from ever wrapping.
    localparam int FW = SW + SHIFT + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);
    localparam logic [PW-1:0] WP_LAST  = PW'(WIN - 1);
    localparam logic [FW-1:0] WIN_F    = FW'(WIN);
`ifdef CS_ROUND_EN
    localparam logic [FW-1:0] RND = FW'((2 ** SHIFT) / 2);
`else
    localparam logic [FW-1:0] RND = '0;
`endif

    logic [WIN-1:0][DATA_W-1:0] mem_q;
    logic [PW-1:0]              wp_q, wp_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [SW-1:0]              sum_q, sum_d;
    logic                       pend_q;
    logic [OUT_W-1:0]           y_q, y_d;
    logic                       vld_q;
    logic                       acc;
    logic [DATA_W-1:0]          old;
    logic [DATA_W-1:0]          xa;
    logic [FW-1:0]              y_full;

    assign acc = in_valid && !clear;

    // Oldest sample only leaves the sum once the window is full; before that the slot is stale.
    always_comb begin
        old   = (cnt_q == CNT_FULL) ? mem_q[wp_q] : '0;
        sum_d = sum_q + SW'(X) - SW'(old);
        wp_d  = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
        cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
    end

    // X_appr: largest entry with entry*WIN <= sum, i.e. not above the average, without a divider.
    always_comb begin
        xa = '0;
        for (int i = 0; i < WIN; i++) begin
            if ((FW'(mem_q[i]) * WIN_F) <= FW'(sum_q) && mem_q[i] > xa)
                xa = mem_q[i];
        end
        y_full = FW'(sum_q) + FW'(xa) * WIN_F + RND;
        y_d    = OUT_W'(y_full >> SHIFT);
    end

    always_ff @(posedge clk) begin
        if (acc) mem_q[wp_q] <= X;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q   <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            pend_q <= 1'b0;
        end else if (clear) begin
            wp_q   <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            pend_q <= 1'b0;
        end else if (in_valid) begin
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            pend_q <= (cnt_q >= CNT_LAST);
        end else begin
            pend_q <= 1'b0;
        end
    end

    // Result of the accept on the previous edge; a clear on this edge cancels it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= pend_q && !clear;
            if (pend_q && !clear) y_q <= y_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_cs_win.sv
// Directed and model-checked bench for cs_win at WIN=9/SHIFT=3 and WIN=4/SHIFT=2.
module tb_cs_win;
    logic       clk = 1'b0;
    logic       reset, in_valid, clear;
    logic [7:0] X;
    logic [9:0] Y, Y4;
    logic       vld, vld4;

    always #5 clk = ~clk;

    cs_win dut (
        .clk(clk), .reset(reset), .X(X), .in_valid(in_valid), .clear(clear),
        .Y(Y), .out_valid(vld)
    );
    cs_win #(.DATA_W(8), .WIN(4), .SHIFT(2), .OUT_W(10)) dut4 (
        .clk(clk), .reset(reset), .X(X), .in_valid(in_valid), .clear(clear),
        .Y(Y4), .out_valid(vld4)
    );

`ifdef CS_ROUND_EN
    localparam int Y_SAT = 574;
    localparam int Y_F10 = 14;
`else
    localparam int Y_SAT = 573;
    localparam int Y_F10 = 13;
`endif

    typedef struct {
        logic v;
        logic c;
        int   x;
        logic ev;
        int   ey;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    // Reference window model for the random phase: index 0 = WIN 9, index 1 = WIN 4.
    int   w[2][64];
    int   n[2];
    int   pend[2];
    int   val[2];
    int   yh[2];
    int   wins[2] = '{9, 4};
    int   shf[2]  = '{3, 2};

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input int x);
        logic [31:0] xv;
        xv = x;
        @(negedge clk);
        in_valid = v;
        clear    = c;
        X        = xv[7:0];
        @(posedge clk);
        #1;
    endtask

    function automatic int model_y(input int d);
        int s, xa, r;
        s  = 0;
        xa = 0;
        for (int i = 0; i < n[d]; i++) s += w[d][i];
        for (int i = 0; i < n[d]; i++)
            if (w[d][i] * n[d] <= s && w[d][i] > xa) xa = w[d][i];
        r = 0;
`ifdef CS_ROUND_EN
        if (shf[d] > 0) r = 1 << (shf[d] - 1);
`endif
        return ((s + n[d] * xa + r) >> shf[d]) & 1023;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; X = 8'd0;
        #12;
        chk("reset_y", int'(Y), 0);
        chk("reset_vld", int'(vld), 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill 1..9 then 10; each row's expectation is what the edge after its inputs shows.
        for (int k = 1; k <= 9; k++) tbl.push_back('{1'b1, 1'b0, k, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 10, 1'b1, 11});
        tbl.push_back('{1'b0, 1'b0, 0, 1'b1, Y_F10});
        tbl.push_back('{1'b0, 1'b0, 0, 1'b0, Y_F10});
        tbl.push_back('{1'b1, 1'b1, 50, 1'b0, Y_F10});
        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r].v, tbl[r].c, tbl[r].x);
            chk($sformatf("tbl%0d_vld", r), int'(vld), int'(tbl[r].ev));
            chk($sformatf("tbl%0d_y", r), int'(Y), tbl[r].ey);
        end

        // Gaps: same fill with idles interleaved.
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0, k);
            chk("gap_acc_vld", int'(vld), 0);
            if (k < 9) repeat (k % 3) begin
                step(1'b0, 1'b0, 0);
                chk("gap_idle_vld", int'(vld), 0);
            end
        end
        step(1'b0, 1'b0, 0);
        chk("gap_out_vld", int'(vld), 1);
        chk("gap_out_y", int'(Y), 11);
        step(1'b0, 1'b0, 0);
        chk("gap_hold_vld", int'(vld), 0);
        chk("gap_hold_y", int'(Y), 11);
        step(1'b1, 1'b0, 10);
        chk("gap_10_vld0", int'(vld), 0);
        step(1'b0, 1'b0, 0);
        chk("gap_10_y", int'(Y), Y_F10);

        // Saturation with full-scale samples.
        step(1'b0, 1'b1, 0);
        for (int j = 1; j <= 12; j++) begin
            step(1'b1, 1'b0, 255);
            if (j >= 10) begin
                chk("sat_vld", int'(vld), 1);
                chk("sat_y", int'(Y), Y_SAT);
            end else begin
                chk("sat_fill_vld", int'(vld), 0);
            end
        end
        step(1'b0, 1'b0, 0);
        chk("sat_last_y", int'(Y), Y_SAT);

        // Clear mid-stream with a simultaneous sample that must be dropped.
        step(1'b0, 1'b1, 0);
        repeat (5) step(1'b1, 1'b0, 40);
        step(1'b1, 1'b1, 77);
        chk("clr_vld", int'(vld), 0);
        chk("clr_hold_y", int'(Y), Y_SAT);
        for (int j = 1; j <= 9; j++) begin
            step(1'b1, 1'b0, 100);
            chk("clr_fill_vld", int'(vld), 0);
        end
        step(1'b0, 1'b0, 0);
        chk("clr_out_vld", int'(vld), 1);
        chk("clr_out_y", int'(Y), 225);

        // Asynchronous reset between edges after 12 accepts.
        repeat (3) step(1'b1, 1'b0, 100);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_y", int'(Y), 0);
        chk("areset_vld", int'(vld), 0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step(1'b1, 1'b0, 100);
            chk("rst_fill_vld", int'(vld), 0);
        end
        step(1'b0, 1'b0, 0);
        chk("rst_out_vld", int'(vld), 1);
        chk("rst_out_y", int'(Y), 225);

        // Small window: 3,8,1,8 -> S=20, X_appr=3, Y=8.
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 3);
        step(1'b1, 1'b0, 8);
        step(1'b1, 1'b0, 1);
        step(1'b1, 1'b0, 8);
        chk("w4_fill_vld", int'(vld4), 0);
        step(1'b0, 1'b0, 0);
        chk("w4_vld", int'(vld4), 1);
        chk("w4_y", int'(Y4), 8);

        // Random stream against the reference model on both instances.
        step(1'b0, 1'b1, 0);
        for (int d = 0; d < 2; d++) begin
            n[d] = 0; pend[d] = 0; val[d] = 0;
        end
        yh[0] = 225;
        yh[1] = 8;
        begin
            int   acc;
            logic v, c;
            int   x;
            int   ev[2];
            acc = 0;
            while (acc < 2000) begin
                v = ($urandom_range(0, 9) < 7);
                c = ($urandom_range(0, 59) == 0);
                case ($urandom_range(0, 7))
                    0: x = 0;
                    1: x = 255;
                    default: x = $urandom_range(0, 255);
                endcase
                for (int d = 0; d < 2; d++) begin
                    ev[d] = (pend[d] != 0 && !c) ? 1 : 0;
                    if (ev[d] != 0) yh[d] = val[d];
                    if (c) begin
                        n[d] = 0; pend[d] = 0;
                    end else if (v) begin
                        if (n[d] == wins[d]) begin
                            for (int i = 0; i < wins[d] - 1; i++) w[d][i] = w[d][i+1];
                            w[d][wins[d]-1] = x;
                        end else begin
                            w[d][n[d]] = x;
                            n[d]++;
                        end
                        pend[d] = (n[d] == wins[d]) ? 1 : 0;
                        if (pend[d] != 0) val[d] = model_y(d);
                    end else begin
                        pend[d] = 0;
                    end
                end
                if (v && !c) acc++;
                step(v, c, x);
                chk("rnd9_vld", int'(vld), ev[0]);
                chk("rnd9_y", int'(Y), yh[0]);
                chk("rnd4_vld", int'(vld4), ev[1]);
                chk("rnd4_y", int'(Y4), yh[1]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cs_win.md
# cs_win

Parametrised successor to the CS sliding-window approximate-average engine. Keeps the last WIN accepted samples of X. For each new sample it finds the approximate value X_appr: the largest window sample not exceeding the window average. It then outputs Y = (sum + WIN·X_appr) >> SHIFT. Unlike the fixed 9-tap, always-streaming CS, this block takes a valid-qualified input stream with gaps, has a synchronous window clear, and has configurable width, depth and scaling. It sits directly between the sample source and the Y consumer in the CS datapath.

## Interface
- DATA_W, 8, sample width.
- WIN, 9, window depth; legal range 2..64.
- SHIFT, 3, right-shift applied to the final sum (divide by 2^SHIFT).
- OUT_W, 10, output width. It must be at least DATA_W + clog2(2·WIN) − SHIFT (10 at the defaults); otherwise the MSBs are truncated.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- X  in  DATA_W  unsigned input sample.
- in_valid  in  1  X is accepted on any rising edge where this is 1.
- clear  in  1  synchronous window flush; takes priority over in_valid.
- Y  out  OUT_W  result; holds its value while out_valid = 0.
- out_valid  out  1  one-cycle strobe; Y is new this cycle.

## Operation
- Storage: ring buffer of WIN × DATA_W entries, write pointer wp (0..WIN−1), fill counter cnt (0..WIN, saturating), running sum S (DATA_W + clog2(WIN) bits).
- Accept (in_valid = 1, clear = 0):
  - S ← S + X − buf[wp], where buf[wp] counts as 0 while cnt < WIN.
  - buf[wp] ← X.
  - wp wraps from WIN−1 to 0.
  - cnt increments, saturating at WIN.
- Result stage, evaluated combinationally on the post-update buffer and registered on the next edge:
  - X_appr = max over entries with buf[i]·WIN ≤ S. The comparison is exact integer multiply-compare; no divider.
  - A qualifying entry always exists (min ≤ average), so there is no empty-set case.
  - Y ← (S + WIN·X_appr) >> SHIFT, computed at full precision, then truncated to OUT_W.
- out_valid is asserted only for accepts where the post-update cnt = WIN. During fill, accepts 1..WIN−1 produce no output.
- clear = 1: cnt ← 0, wp ← 0, S ← 0, pending result cancelled, out_valid = 0 on the next edge. Buffer contents need not be zeroed; cnt masks them.
- clear and in_valid on the same edge: the clear wins and X is dropped.
- Idle cycles (in_valid = 0) leave window, S and Y unchanged. out_valid is 0.

## Timing
- Reset values: Y = 0, out_valid = 0, cnt = 0, wp = 0, S = 0.
- Reset is asynchronous and takes effect mid-window. After reset deasserts, the next WIN accepts are a fresh fill.
- Latency: a sample accepted at edge k produces Y/out_valid at edge k+1.
- Throughput: one sample per cycle; back-to-back accepts give back-to-back out_valid.
- Gaps: an output depends only on the sequence of accepted samples, not on cycle spacing.
- First output after reset or clear: the edge after the WIN-th accept.
- Wrap-around: the oldest-sample subtraction uses buf[wp] before the overwrite. Behaviour is identical whether the pointer wraps or not.

## Configuration
- CS_ROUND_EN defined: Y = (S + WIN·X_appr + 2^(SHIFT−1)) >> SHIFT, i.e. round-half-up. SHIFT = 0 adds nothing.
- CS_ROUND_EN undefined: floor, with bit-exact compatibility with the original CS golden data at the default parameters.

## Test plan
All cases use default parameters unless stated.
- Fill: accept 1,2,…,9 contiguously → no out_valid for the first 8 accepts; after the 9th, Y = 11 (S = 45, X_appr = 5). Then accept 10 → Y = 13 (S = 54, X_appr = 6).
- Saturation: accept 255 repeatedly → Y = 573 from the 9th accept onward; with CS_ROUND_EN, Y = 574. No overflow.
- Gaps: repeat the fill case with in_valid toggled 1,0,0,1… and random idles → identical Y sequence; out_valid only on the edge after each accept.
- Clear mid-stream: accept 5 samples of 40, pulse clear together with in_valid (X = 77), then accept 9 samples of 100 → X = 77 dropped; first out_valid only after the 9th post-clear sample, Y = 225.
- Async reset: assert reset between clock edges after 12 accepts → Y = 0 and out_valid = 0 immediately; after release, the 9-sample constant-100 window yields Y = 225.
- Parameter sweep: WIN = 4, SHIFT = 2, DATA_W = 8, OUT_W = 10, accept 3,8,1,8 → S = 20, X_appr = 3, Y = (20 + 12) >> 2 = 8; compare all runs against a software reference model over 2000 random samples.
